// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared time-of-day types, limits and 12-hour conversion
package clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int HOUR_W   = 5;
    localparam int MS_W     = 6;

    typedef struct packed {
        logic [HOUR_W-1:0] h;
        logic [MS_W-1:0]   m;
        logic [MS_W-1:0]   s;
    } time_t;

    // Returns {display_hours, pm} for a 24-hour internal hour.
    function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] hh;
        logic              pm;
        pm = (h >= HOUR_W'(12));
        if (h == '0) begin
            hh = HOUR_W'(12);
        end else if (h > HOUR_W'(12)) begin
            hh = h - HOUR_W'(12);
        end else begin
            hh = h;
        end
        return {hh, pm};
    endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// rtl/clock_timekeeper_if.sv - control, load, alarm and display bundle of the timekeeper
interface clock_timekeeper_if;
    import clock_pkg::*;

    logic              run;
    logic              set_en;
    logic [HOUR_W-1:0] set_hours;
    logic [MS_W-1:0]   set_minutes;
    logic [MS_W-1:0]   set_seconds;
    logic              alarm_wr;
    logic [HOUR_W-1:0] alarm_hours;
    logic [MS_W-1:0]   alarm_minutes;
    logic              alarm_en;
    logic              mode_12h;
    logic [MS_W-1:0]   seconds;
    logic [MS_W-1:0]   minutes;
    logic [HOUR_W-1:0] hours;
    logic              pm;
    logic              sec_tick;
    logic              day_wrap;
    logic              alarm_hit;
    logic              set_err;

    modport master (
        output run, set_en, set_hours, set_minutes, set_seconds,
               alarm_wr, alarm_hours, alarm_minutes, alarm_en, mode_12h,
        input  seconds, minutes, hours, pm, sec_tick, day_wrap, alarm_hit, set_err
    );

    modport slave (
        input  run, set_en, set_hours, set_minutes, set_seconds,
               alarm_wr, alarm_hours, alarm_minutes, alarm_en, mode_12h,
        output seconds, minutes, hours, pm, sec_tick, day_wrap, alarm_hit, set_err
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the tick clock down to one advance strobe per second
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic Clk_1sec,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic adv
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] TERM = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] cnt;

    // A clear (time load) suppresses the advance that would otherwise fire this cycle.
    assign adv = run && !clr && (cnt == TERM);

    always_ff @(posedge Clk_1sec) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= adv ? '0 : cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/clock_timekeeper.sv
// rtl/clock_timekeeper.sv - time-of-day counter with validated load, alarm compare and 12/24-hour display
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic Clk_1sec,
    input  logic reset,
    clock_timekeeper_if.slave bus
);

    time_t             t;
    time_t             t_next;
    logic [HOUR_W-1:0] al_h;
    logic [MS_W-1:0]   al_m;
    logic              adv;
    logic              set_ok;
    logic              al_ok;
    logic              load;
    logic              last_sec;
    logic              sec_tick_r;
    logic              day_wrap_r;
    logic              alarm_hit_r;
    logic              set_err_r;
    logic [HOUR_W-1:0] h12;
    logic              pm12;

    assign set_ok = (bus.set_hours   <= HOUR_W'(HOUR_MAX)) &&
                    (bus.set_minutes <= MS_W'(MIN_MAX)) &&
                    (bus.set_seconds <= MS_W'(SEC_MAX));
    assign al_ok  = (bus.alarm_hours   <= HOUR_W'(HOUR_MAX)) &&
                    (bus.alarm_minutes <= MS_W'(MIN_MAX));
    assign load   = bus.set_en && set_ok;

    tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
        .Clk_1sec (Clk_1sec),
        .reset    (reset),
        .run      (bus.run),
        .clr      (load),
        .adv      (adv)
    );

    assign last_sec = (t.h == HOUR_W'(HOUR_MAX)) && (t.m == MS_W'(MIN_MAX)) &&
                      (t.s == MS_W'(SEC_MAX));

    always_comb begin
        t_next = t;
        if (t.s != MS_W'(SEC_MAX)) begin
            t_next.s = t.s + MS_W'(1);
        end else begin
            t_next.s = '0;
            if (t.m != MS_W'(MIN_MAX)) begin
                t_next.m = t.m + MS_W'(1);
            end else begin
                t_next.m = '0;
                t_next.h = (t.h == HOUR_W'(HOUR_MAX)) ? '0 : t.h + HOUR_W'(1);
            end
        end
    end

    // Alarm compare uses the alarm registers as they stood before this edge.
    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            t           <= '0;
            al_h        <= '0;
            al_m        <= '0;
            sec_tick_r  <= 1'b0;
            day_wrap_r  <= 1'b0;
            alarm_hit_r <= 1'b0;
            set_err_r   <= 1'b0;
        end else begin
            sec_tick_r  <= 1'b0;
            day_wrap_r  <= 1'b0;
            alarm_hit_r <= 1'b0;
            set_err_r   <= (bus.set_en && !set_ok) || (bus.alarm_wr && !al_ok);
            if (load) begin
                t <= '{h: bus.set_hours, m: bus.set_minutes, s: bus.set_seconds};
            end else if (adv) begin
                t           <= t_next;
                sec_tick_r  <= 1'b1;
                day_wrap_r  <= last_sec;
                alarm_hit_r <= bus.alarm_en && (t_next.s == '0) &&
                               (t_next.h == al_h) && (t_next.m == al_m);
            end
            if (bus.alarm_wr && al_ok) begin
                al_h <= bus.alarm_hours;
                al_m <= bus.alarm_minutes;
            end
        end
    end

    assign {h12, pm12}   = to_12h(t.h);
    assign bus.seconds   = t.s;
    assign bus.minutes   = t.m;
    assign bus.hours     = bus.mode_12h ? h12 : t.h;
    assign bus.pm        = pm12;
    assign bus.sec_tick  = sec_tick_r;
    assign bus.day_wrap  = day_wrap_r;
    assign bus.alarm_hit = alarm_hit_r;
    assign bus.set_err   = set_err_r;

endmodule

// File: tb/tb_clock_timekeeper.sv
// tb/tb_clock_timekeeper.sv - bench for clock_timekeeper at one and four ticks per second
module tb_clock_timekeeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic [5:0] set_seconds = '0;
    logic       alarm_wr = 1'b0;
    logic [4:0] alarm_hours = '0;
    logic [5:0] alarm_minutes = '0;
    logic       alarm_en = 1'b0;
    logic       mode_12h = 1'b0;

    int total = 0;
    int bad = 0;
    bit armed = 0;

    int tp[2] = '{1, 4};
    int tod[2];
    int pre[2];
    int alm[2];
    bit e_tick[2];
    bit e_wrap[2];
    bit e_hit[2];
    bit e_err[2];

    always #5 clk = ~clk;

    clock_timekeeper_if if1 ();
    clock_timekeeper_if if4 ();

    assign if1.run = run;             assign if4.run = run;
    assign if1.set_en = set_en;       assign if4.set_en = set_en;
    assign if1.set_hours = set_hours; assign if4.set_hours = set_hours;
    assign if1.set_minutes = set_minutes; assign if4.set_minutes = set_minutes;
    assign if1.set_seconds = set_seconds; assign if4.set_seconds = set_seconds;
    assign if1.alarm_wr = alarm_wr;   assign if4.alarm_wr = alarm_wr;
    assign if1.alarm_hours = alarm_hours; assign if4.alarm_hours = alarm_hours;
    assign if1.alarm_minutes = alarm_minutes; assign if4.alarm_minutes = alarm_minutes;
    assign if1.alarm_en = alarm_en;   assign if4.alarm_en = alarm_en;
    assign if1.mode_12h = mode_12h;   assign if4.mode_12h = mode_12h;

    clock_timekeeper #(.TICKS_PER_SEC(1)) u_t1 (.Clk_1sec(clk), .reset(reset), .bus(if1));
    clock_timekeeper #(.TICKS_PER_SEC(4)) u_t4 (.Clk_1sec(clk), .reset(reset), .bus(if4));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: time kept as seconds-of-day, alarm as minute-of-day.
    task automatic model_step(input int k);
        bit sv;
        bit av;
        if (reset) begin
            tod[k] = 0; pre[k] = 0; alm[k] = 0;
            e_tick[k] = 0; e_wrap[k] = 0; e_hit[k] = 0; e_err[k] = 0;
            return;
        end
        sv = (set_hours <= 23) && (set_minutes <= 59) && (set_seconds <= 59);
        av = (alarm_hours <= 23) && (alarm_minutes <= 59);
        e_tick[k] = 0; e_wrap[k] = 0; e_hit[k] = 0;
        e_err[k] = (set_en && !sv) || (alarm_wr && !av);
        if (set_en && sv) begin
            tod[k] = set_hours * 3600 + set_minutes * 60 + set_seconds;
            pre[k] = 0;
        end else if (run) begin
            if (pre[k] == tp[k] - 1) begin
                pre[k] = 0;
                e_wrap[k] = (tod[k] == 86399);
                tod[k] = (tod[k] + 1) % 86400;
                e_tick[k] = 1;
                e_hit[k] = alarm_en && (tod[k] % 60 == 0) && (tod[k] / 60 == alm[k]);
            end else begin
                pre[k]++;
            end
        end
        if (alarm_wr && av) alm[k] = alarm_hours * 60 + alarm_minutes;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic compare_one(input int k, input logic [5:0] s, input logic [5:0] m,
                               input logic [4:0] h, input logic p, input logic tk,
                               input logic wr, input logic hit, input logic err);
        int eh;
        int hd;
        eh = tod[k] / 3600;
        hd = mode_12h ? ((eh % 12 == 0) ? 12 : eh % 12) : eh;
        check($sformatf("t%0d.seconds", tp[k]), 32'(s), 32'(tod[k] % 60));
        check($sformatf("t%0d.minutes", tp[k]), 32'(m), 32'((tod[k] / 60) % 60));
        check($sformatf("t%0d.hours", tp[k]), 32'(h), 32'(hd));
        check($sformatf("t%0d.pm", tp[k]), 32'(p), 32'(eh >= 12));
        check($sformatf("t%0d.sec_tick", tp[k]), 32'(tk), 32'(e_tick[k]));
        check($sformatf("t%0d.day_wrap", tp[k]), 32'(wr), 32'(e_wrap[k]));
        check($sformatf("t%0d.alarm_hit", tp[k]), 32'(hit), 32'(e_hit[k]));
        check($sformatf("t%0d.set_err", tp[k]), 32'(err), 32'(e_err[k]));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            compare_one(0, if1.seconds, if1.minutes, if1.hours, if1.pm,
                        if1.sec_tick, if1.day_wrap, if1.alarm_hit, if1.set_err);
            compare_one(1, if4.seconds, if4.minutes, if4.hours, if4.pm,
                        if4.sec_tick, if4.day_wrap, if4.alarm_hit, if4.set_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_time(input int h, input int m, input int s);
        set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
        set_en = 1'b1;
        tick();
        set_en = 1'b0;
    endtask

    initial begin
        int ticks;
        int wraps;
        int hl[5] = '{0, 11, 12, 13, 23};
        int hx[5] = '{12, 11, 12, 1, 11};
        int px[5] = '{0, 0, 1, 1, 1};

        tick();
        tick();
        armed = 1;
        check("reset.seconds", 32'(if1.seconds), 0);
        check("reset.hours24", 32'(if1.hours), 0);
        check("reset.pm", 32'(if1.pm), 0);
        mode_12h = 1'b1;
        #1;
        check("reset.hours12", 32'(if1.hours), 12);
        mode_12h = 1'b0;

        // Pause test: advance at the 4th run-cycle, cycle 9 after release.
        reset = 1'b0;
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        repeat (5) tick();
        run = 1'b1;
        tick();
        check("pause.c8_t4_seconds", 32'(if4.seconds), 0);
        tick();
        check("pause.c9_t4_seconds", 32'(if4.seconds), 1);
        check("pause.c9_t4_tick", 32'(if4.sec_tick), 1);
        check("pause.c9_t1_seconds", 32'(if1.seconds), 4);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks = 0;
        wraps = 0;
        repeat (3661) begin
            tick();
            if (if1.sec_tick === 1'b1) ticks++;
            if (if1.day_wrap === 1'b1) wraps++;
        end
        run = 1'b0;
        check("run3661.hours", 32'(if1.hours), 1);
        check("run3661.minutes", 32'(if1.minutes), 1);
        check("run3661.seconds", 32'(if1.seconds), 1);
        check("run3661.ticks", 32'(ticks), 3661);
        check("run3661.wraps", 32'(wraps), 0);

        load_time(23, 59, 58);
        check("wrap.loaded_hours", 32'(if1.hours), 23);
        run = 1'b1;
        tick();
        check("wrap.first_seconds", 32'(if1.seconds), 59);
        check("wrap.first_day_wrap", 32'(if1.day_wrap), 0);
        tick();
        run = 1'b0;
        check("wrap.second_hours", 32'(if1.hours), 0);
        check("wrap.second_seconds", 32'(if1.seconds), 0);
        check("wrap.second_day_wrap", 32'(if1.day_wrap), 1);

        load_time(24, 0, 0);
        check("bad24.set_err", 32'(if1.set_err), 1);
        check("bad24.hours", 32'(if1.hours), 0);
        tick();
        check("bad24.set_err_clear", 32'(if1.set_err), 0);
        load_time(10, 60, 5);
        check("bad60.set_err", 32'(if1.set_err), 1);
        check("bad60.hours", 32'(if1.hours), 0);

        run = 1'b1;
        load_time(12, 0, 0);
        run = 1'b0;
        check("coinc.hours", 32'(if1.hours), 12);
        check("coinc.seconds", 32'(if1.seconds), 0);
        check("coinc.sec_tick", 32'(if1.sec_tick), 0);

        alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_wr = 1'b1; alarm_en = 1'b1;
        load_time(7, 29, 59);
        alarm_wr = 1'b0;
        run = 1'b1; tick(); run = 1'b0;
        check("alarm.minutes", 32'(if1.minutes), 30);
        check("alarm.hit", 32'(if1.alarm_hit), 1);
        alarm_en = 1'b0;
        load_time(7, 29, 59);
        run = 1'b1; tick(); run = 1'b0;
        check("alarm_off.hit", 32'(if1.alarm_hit), 0);
        alarm_en = 1'b1;
        load_time(7, 30, 0);
        check("alarm_load.hit", 32'(if1.alarm_hit), 0);

        mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_time(hl[i], 0, 0);
            check($sformatf("mode12.h%0d.hours", hl[i]), 32'(if1.hours), 32'(hx[i]));
            check($sformatf("mode12.h%0d.pm", hl[i]), 32'(if1.pm), 32'(px[i]));
        end
        mode_12h = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            run = ($urandom_range(0, 3) != 0);
            set_en = ($urandom_range(0, 15) == 0);
            set_hours = 5'($urandom_range(0, 25));
            set_minutes = 6'($urandom_range(0, 61));
            set_seconds = 6'($urandom_range(0, 61));
            alarm_wr = ($urandom_range(0, 15) == 0);
            alarm_hours = 5'($urandom_range(0, 24));
            alarm_minutes = 6'($urandom_range(0, 60));
            alarm_en = 1'($urandom_range(0, 1));
            mode_12h = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        set_en = 1'b0; alarm_wr = 1'b0; reset = 1'b0; mode_12h = 1'b0;

        run = 1'b1;
        load_time(13, 45, 10);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("midreset.t4_seconds", 32'(if4.seconds), 0);
        check("midreset.t4_minutes", 32'(if4.minutes), 0);
        check("midreset.t4_hours", 32'(if4.hours), 0);
        check("midreset.t4_pm", 32'(if4.pm), 0);
        check("midreset.t1_sec_tick", 32'(if1.sec_tick), 0);
        mode_12h = 1'b1;
        #1;
        check("midreset.hours12", 32'(if4.hours), 12);
        reset = 1'b0;
        run = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
